// File: rtl/mem_access_ctrl_pkg.sv
// Shared encodings for the memory-access sequencer: access sizes, error codes
// and the sequencer state encoding also used by the control-unit microcode tables.
package mem_access_ctrl_pkg;

    localparam logic [1:0] MAS_BYTE = 2'b00;
    localparam logic [1:0] MAS_HALF = 2'b01;
    localparam logic [1:0] MAS_WORD = 2'b10;
    localparam logic [1:0] MAS_ILL  = 2'b11;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_ALIGN   = 2'b01;
    localparam logic [1:0] ERR_SIZE    = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_DONE   = 2'b10,
        ST_ERROR  = 2'b11
    } state_t;

    // Halfwords need an even byte address, words a word-aligned one.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lane);
        return ((size == MAS_HALF) && lane[0]) ||
               ((size == MAS_WORD) && (lane != 2'b00));
    endfunction

endpackage

// File: rtl/mem_access_ctrl_lane.sv
// Stateless byte-lane steering: store-data replication and write enables on the
// way out, lane extraction with zero extension on the way back.
module mem_lane_steer
    import mem_access_ctrl_pkg::*;
(
    input  logic [1:0]  mas,
    input  logic        rw,
    input  logic [1:0]  lane,
    input  logic [31:0] wdata,
    input  logic [31:0] ram_rdata,
    output logic [3:0]  we,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext
);

    always_comb begin
        we        = 4'b0000;
        wdata_rep = wdata;
        rdata_ext = ram_rdata;
        case (mas)
            MAS_BYTE: begin
                wdata_rep = {4{wdata[7:0]}};
                we        = 4'b0001 << lane;
                rdata_ext = {24'd0, ram_rdata[{lane, 3'b000} +: 8]};
            end
            MAS_HALF: begin
                wdata_rep = {2{wdata[15:0]}};
                we        = 4'b0011 << lane;
                rdata_ext = {16'd0, ram_rdata[{lane[1], 4'b0000} +: 16]};
            end
            MAS_WORD: begin
                we = 4'b1111;
            end
            default: begin
                we = 4'b0000;
            end
        endcase
        // Loads never strobe a write lane.
        if (rw) begin
            we = 4'b0000;
        end
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory-interface sequencer: one RAM transaction per MFA request, variable
// wait states, lane steering, MFC handshake and abort codes for the microprogram.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        mfa,
    input  logic        rw,
    input  logic [1:0]  mas,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        mfc,
    output logic        err,
    output logic [1:0]  err_code,
    output logic        busy,
    output logic        ram_en,
    output logic [3:0]  ram_we,
    output logic [29:0] ram_addr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata,
    input  logic        ram_ready
);

    state_t            state_q, state_d;
    logic              rw_q, rw_d;
    logic [1:0]        mas_q, mas_d;
    logic [1:0]        lane_q, lane_d;
    logic              drop_q, drop_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [31:0]       rdata_d;
    logic              mfc_d, err_d, busy_d;
    logic [1:0]        err_code_d;
    logic              ram_en_d;
    logic [3:0]        ram_we_d;
    logic [29:0]       ram_addr_d;
    logic [31:0]       ram_wdata_d;

    logic              idle;
    logic              abandon;
    logic [1:0]        st_mas, st_lane;
    logic              st_rw;
    logic [3:0]        st_we;
    logic [31:0]       st_wdata, st_rdata;

    assign idle = (state_q == ST_IDLE);

    // In IDLE the steering works on the live request; afterwards on the latched one.
    assign st_mas  = idle ? mas : mas_q;
    assign st_lane = idle ? addr[1:0] : lane_q;
    assign st_rw   = idle ? rw : rw_q;

    mem_lane_steer u_steer (
        .mas       (st_mas),
        .rw        (st_rw),
        .lane      (st_lane),
        .wdata     (wdata),
        .ram_rdata (ram_rdata),
        .we        (st_we),
        .wdata_rep (st_wdata),
        .rdata_ext (st_rdata)
    );

    assign abandon = drop_q || !mfa;

    always_comb begin
        state_d     = state_q;
        rw_d        = rw_q;
        mas_d       = mas_q;
        lane_d      = lane_q;
        drop_d      = drop_q;
        cnt_d       = cnt_q;
        rdata_d     = rdata;
        mfc_d       = mfc;
        err_d       = err;
        err_code_d  = err_code;
        ram_en_d    = ram_en;
        ram_we_d    = ram_we;
        ram_addr_d  = ram_addr;
        ram_wdata_d = ram_wdata;

        case (state_q)
            ST_IDLE: begin
                mfc_d  = 1'b0;
                err_d  = 1'b0;
                drop_d = 1'b0;
                if (mfa) begin
                    rw_d   = rw;
                    mas_d  = mas;
                    lane_d = addr[1:0];
                    if (mas == MAS_ILL) begin
                        state_d    = ST_ERROR;
                        err_code_d = ERR_SIZE;
                        mfc_d      = 1'b1;
                        err_d      = 1'b1;
                    end else if (misaligned(mas, addr[1:0])) begin
                        state_d    = ST_ERROR;
                        err_code_d = ERR_ALIGN;
                        mfc_d      = 1'b1;
                        err_d      = 1'b1;
                    end else begin
                        state_d     = ST_ACCESS;
                        err_code_d  = ERR_NONE;
                        ram_en_d    = 1'b1;
                        ram_we_d    = st_we;
                        ram_addr_d  = addr[31:2];
                        ram_wdata_d = st_wdata;
                        cnt_d       = '0;
                    end
                end
            end

            ST_ACCESS: begin
                // The RAM cannot be cancelled, so a dropped request is only remembered.
                if (!mfa) begin
                    drop_d = 1'b1;
                end
                if (ram_ready) begin
                    ram_en_d = 1'b0;
                    ram_we_d = 4'b0000;
                    if (rw_q) begin
                        rdata_d = st_rdata;
                    end
                    if (abandon) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DONE;
                        mfc_d   = 1'b1;
                    end
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    ram_en_d   = 1'b0;
                    ram_we_d   = 4'b0000;
                    err_code_d = ERR_TIMEOUT;
                    if (abandon) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_ERROR;
                        mfc_d   = 1'b1;
                        err_d   = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_DONE, ST_ERROR: begin
                if (!mfa) begin
                    state_d = ST_IDLE;
                    mfc_d   = 1'b0;
                    err_d   = 1'b0;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q   <= ST_IDLE;
            rw_q      <= 1'b0;
            mas_q     <= MAS_BYTE;
            lane_q    <= 2'b00;
            drop_q    <= 1'b0;
            cnt_q     <= '0;
            rdata     <= '0;
            mfc       <= 1'b0;
            err       <= 1'b0;
            err_code  <= ERR_NONE;
            busy      <= 1'b0;
            ram_en    <= 1'b0;
            ram_we    <= 4'b0000;
            ram_addr  <= '0;
            ram_wdata <= '0;
        end else begin
            state_q   <= state_d;
            rw_q      <= rw_d;
            mas_q     <= mas_d;
            lane_q    <= lane_d;
            drop_q    <= drop_d;
            cnt_q     <= cnt_d;
            rdata     <= rdata_d;
            mfc       <= mfc_d;
            err       <= err_d;
            err_code  <= err_code_d;
            busy      <= busy_d;
            ram_en    <= ram_en_d;
            ram_we    <= ram_we_d;
            ram_addr  <= ram_addr_d;
            ram_wdata <= ram_wdata_d;
        end
    end

endmodule
